i2s_stream_tx: RTL and testbench



---
 rtl/i2s_stream_tx.sv | 148 ++++++++++++++
 tb/tb_i2s_stream_tx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_stream_tx.sv
// I2S transmitter: sample FIFO, BCLK divider and a 2*SAMPLE_W shift register.
// Valid/ready: a word transfers on any Clk edge where in_valid && in_ready; in_ready never depends on in_valid.
module i2s_stream_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int BCLK_DIV   = 16
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          Enable,
  input  logic                          Mono,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SAMPLE_W-1:0]           in_left,
  input  logic [SAMPLE_W-1:0]           in_right,
  input  logic                          Clear_underrun,
  output logic                          BCLK,
  output logic                          LRCLK,
  output logic                          SDATA,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = 2 * SAMPLE_W;
  localparam int BW = $clog2(FW);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(FW - 1);
  localparam logic [BW-1:0] B_LR_LO  = BW'(SAMPLE_W - 1);
  localparam logic [BW-1:0] B_LR_HI  = BW'(FW - 2);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  logic [FW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_primed;
  logic          r_underrun;

  logic [DW-1:0] r_div;
  logic          r_bclk;
  logic          r_lrclk;
  logic [BW-1:0] r_b;
  logic [FW-1:0] r_shift;

  logic          w_tc;
  logic          w_fall;
  logic          w_boundary;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [BW-1:0] w_b_next;
  logic [FW-1:0] w_head;
  logic [FW-1:0] w_load;

  always_comb begin
    w_tc       = (r_div == DIV_LAST);
    w_fall     = Enable && w_tc && r_bclk;
    w_boundary = w_fall && (r_b == B_LAST);
    w_empty    = (r_count == '0);
    w_push     = in_valid && in_ready;
    w_pop      = w_boundary && !w_empty;
    w_b_next   = (r_b == B_LAST) ? '0 : r_b + 1'b1;
    w_head     = r_mem[r_rd_ptr];
    w_load     = '0;
    if (!w_empty) begin
      w_load = Mono ? {w_head[FW-1:SAMPLE_W], w_head[FW-1:SAMPLE_W]} : w_head;
    end
  end

  assign in_ready   = (r_count < DEPTH_C);
  assign fill_level = r_count;
  assign underrun   = r_underrun;
  assign BCLK       = r_bclk;
  assign LRCLK      = r_lrclk;
  assign SDATA      = r_shift[FW-1];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_left, in_right};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_primed <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_primed <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A set in the same cycle as a clear request wins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_underrun <= 1'b0;
    end else if (w_boundary && w_empty && r_primed) begin
      r_underrun <= 1'b1;
    end else if (Clear_underrun) begin
      r_underrun <= 1'b0;
    end
  end

  // Disable parks b at the last bit so the first fall after enable is a frame boundary.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_div   <= '0;
      r_bclk  <= 1'b0;
      r_lrclk <= 1'b0;
      r_b     <= B_LAST;
      r_shift <= '0;
    end else if (!Enable) begin
      r_div   <= '0;
      r_bclk  <= 1'b0;
      r_lrclk <= 1'b0;
      r_b     <= B_LAST;
      r_shift <= '0;
    end else begin
      r_div <= w_tc ? '0 : r_div + 1'b1;
      if (w_tc) begin
        r_bclk <= ~r_bclk;
      end
      if (w_fall) begin
        r_b     <= w_b_next;
        r_lrclk <= (w_b_next >= B_LR_LO) && (w_b_next <= B_LR_HI);
        r_shift <= w_boundary ? w_load : {r_shift[FW-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_i2s_stream_tx.sv
// Directed bench for i2s_stream_tx: table of serialised frames plus hand-written corner sequences.
module tb_i2s_stream_tx;

  localparam int SW    = 16;
  localparam int DEPTH = 4;
  localparam int DIV   = 2;
  localparam int CW    = 3;
  localparam logic [31:0] LR_MASK = 32'h0001_FFFE;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          mono;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_left;
  logic [SW-1:0] in_right;
  logic          clear_underrun;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          underrun;
  logic [CW-1:0] fill_level;

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [15:0] left;
    logic [15:0] right;
    logic        mono;
    logic [31:0] exp_frame;
  } vec_t;

  vec_t vecs[5];

  i2s_stream_tx #(
    .SAMPLE_W  (SW),
    .FIFO_DEPTH(DEPTH),
    .BCLK_DIV  (DIV)
  ) dut (
    .Clk           (clk),
    .Reset_n       (rst_n),
    .Enable        (enable),
    .Mono          (mono),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_left       (in_left),
    .in_right      (in_right),
    .Clear_underrun(clear_underrun),
    .BCLK          (bclk),
    .LRCLK         (lrclk),
    .SDATA         (sdata),
    .underrun      (underrun),
    .fill_level    (fill_level)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    check_cnt++;
    $display("FAIL %s: timed out waiting for BCLK edge", name);
  endtask

  task automatic wait_rise(output bit ok);
    logic prev;
    prev = bclk;
    ok   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bclk && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = bclk;
    end
  endtask

  task automatic wait_fall(output bit ok);
    logic prev;
    prev = bclk;
    ok   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bclk && prev) begin
        ok = 1'b1;
        break;
      end
      prev = bclk;
    end
  endtask

  // Samples SDATA/LRCLK at the 32 BCLK rises of one frame, MSB first.
  task automatic capture_frame(input bit skip_first, output logic [31:0] data, output logic [31:0] lr);
    bit ok;
    data = '0;
    lr   = '0;
    if (skip_first) begin
      wait_rise(ok);
      if (!ok) begin
        timeout_fail("capture_skip");
        return;
      end
    end
    for (int k = 0; k < 32; k++) begin
      wait_rise(ok);
      if (!ok) begin
        timeout_fail("capture_bit");
        return;
      end
      data[31-k] = sdata;
      lr[31-k]   = lrclk;
    end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] lr;
    logic [31:0] exp;
    bit          ok;
    int          accepted;
    int          cyc;
    bit          seen;
    int          bad;

    vecs[0] = '{16'hA5C3, 16'h0F0F, 1'b0, 32'hA5C3_0F0F};
    vecs[1] = '{16'h8001, 16'hFFFF, 1'b1, 32'h8001_8001};
    vecs[2] = '{16'h7FFF, 16'h8000, 1'b0, 32'h7FFF_8000};
    vecs[3] = '{16'h0000, 16'hFFFF, 1'b0, 32'h0000_FFFF};
    vecs[4] = '{16'h1234, 16'hABCD, 1'b1, 32'h1234_1234};

    rst_n          = 1'b0;
    enable         = 1'b0;
    mono           = 1'b0;
    in_valid       = 1'b0;
    in_left        = '0;
    in_right       = '0;
    clear_underrun = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outputs", {29'd0, bclk, lrclk, sdata}, 32'd0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_fill", fill_level, 3'd0);
    check("rst_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Never pushed: silent frames, LRCLK still framed, no underrun
    enable = 1'b1;
    capture_frame(1'b1, d, lr);
    check("idle_frame1_data", d, 32'd0);
    check("idle_frame1_lrclk", lr, LR_MASK);
    capture_frame(1'b0, d, lr);
    check("idle_frame2_data", d, 32'd0);
    check("idle_no_underrun", underrun, 1'b0);
    enable = 1'b0;

    // Table-driven single-frame serialisation
    for (int i = 0; i < 5; i++) begin
      mono = vecs[i].mono;
      push(vecs[i].left, vecs[i].right);
      exp_q.push_back(vecs[i].exp_frame);
      check($sformatf("vec%0d_fill_pre", i), fill_level, 3'd1);
      enable = 1'b1;
      capture_frame(1'b1, d, lr);
      enable = 1'b0;
      exp = exp_q.pop_front();
      check($sformatf("vec%0d_sdata", i), d, exp);
      check($sformatf("vec%0d_lrclk", i), lr, LR_MASK);
      check($sformatf("vec%0d_fill_post", i), fill_level, 3'd0);
    end

    // Mono: one entry consumed per frame
    mono = 1'b1;
    push(16'h8001, 16'hFFFF);
    push(16'h0180, 16'h1234);
    check("mono_fill_2", fill_level, 3'd2);
    enable = 1'b1;
    capture_frame(1'b1, d, lr);
    check("mono_frame1", d, 32'h8001_8001);
    check("mono_fill_1", fill_level, 3'd1);
    capture_frame(1'b0, d, lr);
    check("mono_frame2", d, 32'h0180_0180);
    check("mono_fill_0", fill_level, 3'd0);
    enable = 1'b0;
    mono   = 1'b0;

    // Underrun set, cleared, re-set
    push(16'hF00F, 16'h3C3C);
    enable = 1'b1;
    capture_frame(1'b1, d, lr);
    check("ur_frame1", d, 32'hF00F_3C3C);
    check("ur_before_boundary", underrun, 1'b0);
    wait_fall(ok);
    if (!ok) timeout_fail("ur_boundary_wait");
    else check("ur_set_at_boundary", underrun, 1'b1);
    capture_frame(1'b0, d, lr);
    check("ur_frame2_zero", d, 32'd0);
    clear_underrun = 1'b1;
    @(negedge clk);
    clear_underrun = 1'b0;
    check("ur_cleared", underrun, 1'b0);
    wait_fall(ok);
    if (!ok) timeout_fail("ur_reset_wait");
    else check("ur_set_again", underrun, 1'b1);
    enable = 1'b0;

    // Backpressure while disabled
    @(negedge clk);
    in_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      in_left  = 16'h1000 + 16'(i);
      in_right = 16'h2000 + 16'(i);
      if (in_ready) accepted++;
      @(negedge clk);
    end
    check("bp_accepted", 32'(accepted), 32'd4);
    check("bp_ready_low", in_ready, 1'b0);
    check("bp_fill_full", fill_level, 3'd4);

    // Full FIFO across a boundary with in_valid still high
    enable = 1'b1;
    cyc    = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (fill_level != 3'd4) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout_fail("full_pop_wait");
    else begin
      check("full_pop_fill", fill_level, 3'd3);
      check("full_pop_ready", in_ready, 1'b1);
      check("first_pop_latency", 32'(cyc), 32'd4);
      @(negedge clk);
      check("full_refill", fill_level, 3'd4);
      check("full_refill_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;

    // Asynchronous reset at b=10
    for (int i = 0; i < 11; i++) begin
      wait_rise(ok);
      if (!ok) begin
        timeout_fail("rst_mid_wait");
        break;
      end
    end
    check("bclk_high_before_reset", bclk, 1'b1);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("async_rst_outputs", {29'd0, bclk, lrclk, sdata}, 32'd0);
    check("async_rst_underrun", underrun, 1'b0);
    check("async_rst_fill", fill_level, 3'd0);
    check("async_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Enable drop mid-frame; pushes continue; abandoned sample not replayed
    push(16'hAAAA, 16'h5555);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_rise(ok);
      if (!ok) begin
        timeout_fail("dis_mid_wait");
        break;
      end
    end
    enable = 1'b0;
    @(negedge clk);
    check("dis_outputs_low", {29'd0, bclk, lrclk, sdata}, 32'd0);
    check("dis_fill_popped", fill_level, 3'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i == 2) || (i == 3);
      in_left  = (i == 3) ? 16'hC3C3 : 16'hB00B;
      in_right = (i == 3) ? 16'h0FF0 : 16'h1221;
      @(negedge clk);
      if (bclk || lrclk || sdata) bad++;
    end
    in_valid = 1'b0;
    check("dis_outputs_held", 32'(bad), 32'd0);
    check("dis_fill_pushes", fill_level, 3'd2);
    enable = 1'b1;
    capture_frame(1'b1, d, lr);
    enable = 1'b0;
    check("dis_not_replayed", d, 32'hB00B_1221);
    check("dis_fill_after", fill_level, 3'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
